// File: rtl/proc_pkg.sv
// ============================================================================
// Module      : proc_pkg
// Description : Shared types and constants for the processor front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package proc_pkg;

  // Parameter defaults for the fetch stage
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 21;
  localparam int DEF_PC_W     = 32;
  localparam int DEF_VEC_ADDR = 0;

  // Encoding of a bubble on the FD register
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  // Set in the first word of a two-word instruction
  localparam int TWO_WORD_BIT = 15;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    VEC_HI = 2'd0,
    VEC_LO = 2'd1,
    RUN    = 2'd2,
    IMM    = 2'd3
  } fetch_state_t;

endpackage : proc_pkg

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module      : pc_reg
// Description : Program counter with half-word loads (reset vector), full
//               load (redirect) and increment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_reg #(
  parameter int PC_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load_hi,
  input  logic              load_lo,
  input  logic              load_full,
  input  logic [PC_W/2-1:0] half_d,
  input  logic [PC_W-1:0]   full_d,
  output logic [PC_W-1:0]   pc_q
);

  localparam int            c_half_w = PC_W / 2;
  localparam logic [PC_W-1:0] c_one  = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] r_pc;

  // Full load wins over half loads, which win over increment; increment wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (load_full) begin
      r_pc <= full_d;
    end else if (load_hi) begin
      r_pc[PC_W-1:c_half_w] <= half_d;
    end else if (load_lo) begin
      r_pc[c_half_w-1:0] <= half_d;
    end else if (en) begin
      r_pc <= r_pc + c_one;
    end
  end

  assign pc_q = r_pc;

endmodule : pc_reg

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch. Loads the start PC from the reset vector,
//               fetches one- and two-word instructions and drives the FD
//               pipeline register. Handles load-use stall and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import proc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PC_W     = DEF_PC_W,
  parameter int VEC_ADDR = DEF_VEC_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] fd_instr,
  output logic [DATA_W-1:0] fd_imm,
  output logic [PC_W-1:0]   fd_pc,
  output logic              fd_valid
);

  localparam logic [ADDR_W-1:0] c_vec_hi_addr = ADDR_W'(VEC_ADDR);
  localparam logic [ADDR_W-1:0] c_vec_lo_addr = ADDR_W'(VEC_ADDR + 1);
  localparam logic [DATA_W-1:0] c_nop         = DATA_W'(NOP_INSTR);

  fetch_state_t    r_state;
  logic [DATA_W-1:0] r_hold_instr;
  logic [PC_W-1:0]   r_hold_pc;
  logic [DATA_W-1:0] r_fd_instr;
  logic [DATA_W-1:0] r_fd_imm;
  logic [PC_W-1:0]   r_fd_pc;
  logic              r_fd_valid;
  logic [PC_W-1:0]   w_pc;
  logic              w_running;
  logic              w_advance;

  // Stall and redirect only matter once the vector has been loaded
  assign w_running = (r_state == RUN) || (r_state == IMM);
  assign w_advance = w_running && !redirect && !stall;

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .en        (w_advance),
    .load_hi   (r_state == VEC_HI),
    .load_lo   (r_state == VEC_LO),
    .load_full (w_running && redirect),
    .half_d    (imem_data),
    .full_d    (redirect_pc),
    .pc_q      (w_pc)
  );

  // Address the vector halves during boot, otherwise the truncated PC
  always_comb begin
    imem_addr = w_pc[ADDR_W-1:0];
    if (r_state == VEC_HI) begin
      imem_addr = c_vec_hi_addr;
    end else if (r_state == VEC_LO) begin
      imem_addr = c_vec_lo_addr;
    end
  end

  // Sequencer, hold register for two-word instructions and FD register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= VEC_HI;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_fd_instr   <= c_nop;
      r_fd_imm     <= '0;
      r_fd_pc      <= '0;
      r_fd_valid   <= 1'b0;
    end else begin
      case (r_state)
        VEC_HI: r_state <= VEC_LO;
        VEC_LO: r_state <= RUN;
        default: begin
          if (redirect) begin
            // Any half-fetched two-word instruction is dropped
            r_state    <= RUN;
            r_fd_valid <= 1'b0;
            r_fd_instr <= c_nop;
          end else if (!stall) begin
            if (r_state == IMM) begin
              r_fd_instr <= r_hold_instr;
              r_fd_imm   <= imem_data;
              r_fd_pc    <= r_hold_pc;
              r_fd_valid <= 1'b1;
              r_state    <= RUN;
            end else if (imem_data[TWO_WORD_BIT]) begin
              r_hold_instr <= imem_data;
              r_hold_pc    <= w_pc;
              r_fd_valid   <= 1'b0;
              r_state      <= IMM;
            end else begin
              r_fd_instr <= imem_data;
              r_fd_imm   <= '0;
              r_fd_pc    <= w_pc;
              r_fd_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign fd_instr = r_fd_instr;
  assign fd_imm   = r_fd_imm;
  assign fd_pc    = r_fd_pc;
  assign fd_valid = r_fd_valid;

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with directed scenarios
//               and randomized stall/redirect traffic against a reference
//               model of the fetched instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [20:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] fd_instr;
  logic [15:0] fd_imm;
  logic [31:0] fd_pc;
  logic        fd_valid;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .fd_instr    (fd_instr),
    .fd_imm      (fd_imm),
    .fd_pc       (fd_pc),
    .fd_valid    (fd_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: sparse, unwritten words read as a one-word pattern
  logic [15:0] mem [int unsigned];
  int          mem_gen = 0;

  function automatic logic [15:0] mem_rd(input logic [20:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return {1'b0, a[14:0]};
  endfunction

  task automatic mem_wr(input int unsigned a, input logic [15:0] d);
    mem[a] = d;
    mem_gen++;
  endtask

  always @(imem_addr or mem_gen) imem_data = mem_rd(imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: boot progress, architectural PC, an optional pending
  // first word awaiting its immediate, and the last value shown to decode
  int          m_boot;       // number of vector halves loaded (0..2)
  logic [31:0] m_pc;
  bit          m_pend;
  logic [15:0] m_pend_word;
  logic [31:0] m_pend_pc;
  logic [15:0] m_instr, m_imm;
  logic [31:0] m_fpc;
  bit          m_valid;

  function automatic logic [20:0] exp_addr();
    if (m_boot == 0) return 21'd0;
    if (m_boot == 1) return 21'd1;
    return m_pc[20:0];
  endfunction

  task automatic model_reset();
    m_boot = 0; m_pc = '0; m_pend = 0; m_pend_word = '0; m_pend_pc = '0;
    m_instr = 16'h0000; m_imm = '0; m_fpc = '0; m_valid = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] rpc);
    logic [15:0] w;
    w = mem_rd(exp_addr());
    if (m_boot == 0) begin
      m_pc = {w, m_pc[15:0]}; m_boot = 1;
    end else if (m_boot == 1) begin
      m_pc = {m_pc[31:16], w}; m_boot = 2;
    end else if (r) begin
      m_pc = rpc; m_pend = 0; m_valid = 0; m_instr = 16'h0000;
    end else if (!s) begin
      if (m_pend) begin
        m_instr = m_pend_word; m_imm = w; m_fpc = m_pend_pc; m_valid = 1; m_pend = 0;
      end else if (w >= 16'h8000) begin
        m_pend_word = w; m_pend_pc = m_pc; m_pend = 1; m_valid = 0;
      end else begin
        m_instr = w; m_imm = 16'h0000; m_fpc = m_pc; m_valid = 1;
      end
      m_pc = m_pc + 32'd1;
    end
  endtask

  // Reset asserted between edges; outputs must return to reset values at once
  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    #1;
    chk("rst_valid", {31'd0, fd_valid}, 32'd0);
    chk("rst_instr", {16'd0, fd_instr}, 32'd0);
    chk("rst_imm",   {16'd0, fd_imm},   32'd0);
    chk("rst_pc",    fd_pc,             32'd0);
    chk("rst_addr",  {11'd0, imem_addr}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // One clock: check address before the edge, FD register after it
  task automatic step(input bit s, input bit r, input logic [31:0] rpc);
    stall = s; redirect = r; redirect_pc = rpc;
    #1;
    chk("imem_addr", {11'd0, imem_addr}, {11'd0, exp_addr()});
    @(posedge clk);
    model_step(s, r, rpc);
    #1;
    chk("fd_valid", {31'd0, fd_valid}, {31'd0, m_valid});
    chk("fd_instr", {16'd0, fd_instr}, {16'd0, m_instr});
    chk("fd_imm",   {16'd0, fd_imm},   {16'd0, m_imm});
    chk("fd_pc",    fd_pc,             m_fpc);
  endtask

  initial begin
    model_reset();
    // Boot vector 0x10 and the mixed stream
    mem_wr(0, 16'h0000); mem_wr(1, 16'h0010);
    mem_wr(16, 16'h0123); mem_wr(17, 16'h8045); mem_wr(18, 16'hBEEF);
    @(posedge clk);
    do_reset();
    step(0, 0, 0);
    chk("t1_not_early", {31'd0, fd_valid}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t1_first_pc", fd_pc, 32'h10);
    chk("t1_first_instr", {16'd0, fd_instr}, 32'h0123);
    // Two stall cycles holding M[16]
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t3_hold_pc", fd_pc, 32'h10);
    chk("t3_hold_addr", {11'd0, imem_addr}, 32'd17);
    step(0, 0, 0);
    chk("t2_bubble", {31'd0, fd_valid}, 32'd0);
    step(0, 0, 0);
    chk("t2_two_instr", {16'd0, fd_instr}, 32'h8045);
    chk("t2_two_imm", {16'd0, fd_imm}, 32'hBEEF);
    chk("t2_two_pc", fd_pc, 32'd17);
    chk("t2_next_addr", {11'd0, imem_addr}, 32'd19);
    // Redirect while waiting for the immediate
    step(0, 1, 32'd17);
    step(0, 0, 0);
    step(0, 1, 32'h40);
    chk("t4_valid", {31'd0, fd_valid}, 32'd0);
    chk("t4_nop", {16'd0, fd_instr}, 32'h0000);
    step(0, 0, 0);
    chk("t4_target_pc", fd_pc, 32'h40);
    // Redirect beats stall
    step(1, 1, 32'h20);
    chk("t5_valid", {31'd0, fd_valid}, 32'd0);
    chk("t5_addr", {11'd0, imem_addr}, 32'h20);
    step(0, 0, 0);
    // Reset while in the immediate-fetch state
    step(0, 1, 32'd17);
    step(0, 0, 0);
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // PC wrap from 0xFFFF_FFFF
    mem.delete();
    mem_wr(0, 16'hFFFF); mem_wr(1, 16'hFFFF); mem_wr(21'h1FFFFF, 16'h0005);
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_top_pc", fd_pc, 32'hFFFF_FFFF);
    chk("t6_wrap_addr", {11'd0, imem_addr}, 32'd0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_zero_pc", fd_pc, 32'd0);
    chk("t6_zero_imm", {16'd0, fd_imm}, 32'h0000_FFFF);

    // Randomized memory contents, stalls and redirects
    for (int round = 0; round < 5; round++) begin
      mem.delete();
      for (int a = 0; a < 2048; a++) mem_wr(a, 16'($urandom_range(0, 65535)));
      mem_wr(0, 16'h0000);
      mem_wr(1, 16'($urandom_range(16'h0100, 16'h0700)));
      do_reset();
      for (int c = 0; c < 300; c++) begin
        step($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
             32'($urandom_range(0, 2047)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_fetch_stage

`default_nettype wire
